// File: rtl/handshake_mailbox_pkg.sv
// Shared helpers and constants for the multi-channel handshake mailbox.
// Sizing functions are evaluated at elaboration time by the top and the arbiter.
package handshake_mailbox_pkg;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // A single channel still needs a one-bit tag.
    function automatic int wid_ch_of(input int num_ch);
        return (clog2(num_ch) < 1) ? 1 : clog2(num_ch);
    endfunction

    function automatic int entry_width(input int num_ch, input int wid_data);
        return wid_ch_of(num_ch) + wid_data;
    endfunction

    // LastGrant resets to the highest channel so channel 0 wins first.
    function automatic int last_grant_rst(input int num_ch);
        return num_ch - 1;
    endfunction

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_WID_DATA  = 8;
    localparam int DEF_WID_ENTRY = entry_width(DEF_NUM_CH, DEF_WID_DATA);

endpackage

// File: rtl/handshake_mailbox_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester after the last
// winner, wrapping modulo NUM_CH.
module rr_arbiter
    import handshake_mailbox_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int WID_CH = wid_ch_of(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [WID_CH-1:0] i_last_grant,
    output logic [WID_CH-1:0] o_grant,
    output logic              o_any_grant
);

    logic [WID_CH-1:0] w_grant;
    logic              w_found;
    int                w_idx;

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_idx = (int'(i_last_grant) + k) % NUM_CH;
            if (!w_found && i_req[w_idx]) begin
                w_found = 1'b1;
                w_grant = WID_CH'(w_idx);
            end
        end
    end

    assign o_grant     = w_grant;
    assign o_any_grant = w_found;

endmodule

// File: rtl/handshake_mailbox.sv
// Multi-channel start/data mailbox: per-channel hold registers merged by a
// round-robin arbiter into a valid/ready FIFO. Optional macro: HS_OVERRUN_EN.
module handshake_mailbox
    import handshake_mailbox_pkg::*;
#(
    parameter  int NUM_CH   = 4,
    parameter  int WID_DATA = 8,
    parameter  int DEPTH    = 4,
    localparam int WID_CH   = wid_ch_of(NUM_CH)
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NUM_CH-1:0]          Ch_Start,
    input  logic [NUM_CH*WID_DATA-1:0] Ch_Data,
    output logic [NUM_CH-1:0]          Ch_Busy,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic [WID_DATA-1:0]        Out_Data,
    output logic [WID_CH-1:0]          Out_Channel
`ifdef HS_OVERRUN_EN
    ,
    output logic [NUM_CH-1:0]          Ovr_Flags,
    input  logic [NUM_CH-1:0]          Ovr_Clear
`endif
);

    localparam int WID_PTR   = clog2(DEPTH);
    localparam int WID_CNT   = WID_PTR + 1;
    localparam int WID_ENTRY = entry_width(NUM_CH, WID_DATA);
    localparam logic [WID_CH-1:0]  LAST_GRANT_RST = WID_CH'(last_grant_rst(NUM_CH));
    localparam logic [WID_CNT-1:0] COUNT_FULL     = WID_CNT'(DEPTH);

    logic [NUM_CH-1:0]    r_pending;
    logic [WID_DATA-1:0]  r_hold [NUM_CH];
    logic [WID_CH-1:0]    r_last_grant;
    logic [WID_ENTRY-1:0] r_mem [DEPTH];
    logic [WID_PTR-1:0]   r_wr_ptr;
    logic [WID_PTR-1:0]   r_rd_ptr;
    logic [WID_CNT-1:0]   r_count;

    logic [WID_CH-1:0]    w_grant;
    logic                 w_any;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [WID_ENTRY-1:0] w_head;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .i_req        (r_pending),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any_grant  (w_any)
    );

    assign w_full  = (r_count == COUNT_FULL);
    assign w_empty = (r_count == '0);
    // Full is judged on the current count, so a pop never frees a slot the same cycle.
    assign w_push  = w_any && !w_full;
    assign w_pop   = !w_empty && Out_Ready;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pending <= '0;
            for (int i = 0; i < NUM_CH; i++) r_hold[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_push && (w_grant == WID_CH'(i))) begin
                    r_pending[i] <= 1'b0;
                end else if (Ch_Start[i] && !r_pending[i]) begin
                    r_pending[i] <= 1'b1;
                    r_hold[i]    <= Ch_Data[i*WID_DATA +: WID_DATA];
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_last_grant <= LAST_GRANT_RST;
        end else if (w_push) begin
            r_last_grant <= w_grant;
        end
    end

    // NOTE: the FIFO array is reset on purpose so the head reads zero after reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int d = 0; d < DEPTH; d++) r_mem[d] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_grant, r_hold[w_grant]};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign Ch_Busy     = r_pending;
    assign Out_Valid   = !w_empty;
    assign Out_Data    = w_head[WID_DATA-1:0];
    assign Out_Channel = w_head[WID_ENTRY-1 -: WID_CH];

`ifdef HS_OVERRUN_EN
    logic [NUM_CH-1:0] r_ovr_flags;

    // A start landing on a pending channel sets the sticky flag; set beats clear.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_ovr_flags <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (Ch_Start[i] && r_pending[i]) begin
                    r_ovr_flags[i] <= 1'b1;
                end else if (Ovr_Clear[i]) begin
                    r_ovr_flags[i] <= 1'b0;
                end
            end
        end
    end

    assign Ovr_Flags = r_ovr_flags;
`else
    // Overrun starts are dropped silently; no flag state exists in this build.
`endif

endmodule

// File: tb/tb_handshake_mailbox.sv
// Self-checking bench for handshake_mailbox: queue-based reference model,
// per-cycle output compare, and directed literal expectations.
module tb_handshake_mailbox;

    localparam int NUM_CH   = 4;
    localparam int WID_DATA = 8;
    localparam int DEPTH    = 4;
    localparam int WID_CH   = 2;

    logic                       Clock = 1'b0;
    logic                       Reset = 1'b1;
    logic [NUM_CH-1:0]          Ch_Start = '0;
    logic [NUM_CH*WID_DATA-1:0] Ch_Data = '0;
    logic [NUM_CH-1:0]          Ch_Busy;
    logic                       Out_Valid;
    logic                       Out_Ready = 1'b0;
    logic [WID_DATA-1:0]        Out_Data;
    logic [WID_CH-1:0]          Out_Channel;
    logic [NUM_CH-1:0]          Ovr_Clear = '0;
`ifdef HS_OVERRUN_EN
    logic [NUM_CH-1:0]          Ovr_Flags;
`endif

    handshake_mailbox #(.NUM_CH(NUM_CH), .WID_DATA(WID_DATA), .DEPTH(DEPTH)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Ch_Start    (Ch_Start),
        .Ch_Data     (Ch_Data),
        .Ch_Busy     (Ch_Busy),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .Out_Data    (Out_Data),
        .Out_Channel (Out_Channel)
`ifdef HS_OVERRUN_EN
        ,
        .Ovr_Flags   (Ovr_Flags),
        .Ovr_Clear   (Ovr_Clear)
`endif
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending flags, held words, and a queue of {channel,data}.
    bit  model_live = 1'b0;
    bit  m_pend [NUM_CH];
    int  m_hold [NUM_CH];
    bit  m_ovr  [NUM_CH];
    int  m_last;
    int  m_q [$];
    int  n_accepted = 0;
    int  n_delivered = 0;
    bit  rr_en = 1'b0;
    int  rr_prev = -1;

    always @(posedge Clock) begin
        if (Reset) begin
            model_live = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                m_pend[i] = 1'b0;
                m_ovr[i]  = 1'b0;
            end
            m_q.delete();
            m_last      = NUM_CH - 1;
            n_accepted  = 0;
            n_delivered = 0;
        end else if (model_live) begin : step_model
            bit full;
            bit any;
            int g;
            int e;
            full = (m_q.size() == DEPTH);
            any  = 1'b0;
            g    = 0;
            for (int k = 1; k <= NUM_CH; k++) begin
                if (!any && m_pend[(m_last + k) % NUM_CH]) begin
                    any = 1'b1;
                    g   = (m_last + k) % NUM_CH;
                end
            end
            if (m_q.size() != 0 && Out_Ready) begin
                e = m_q.pop_front();
                n_delivered++;
                if (rr_en) begin
                    if (rr_prev >= 0) check("rr_order", e / 256, (rr_prev + 1) % NUM_CH);
                    rr_prev = e / 256;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (Ch_Start[i] && m_pend[i]) begin
                    m_ovr[i] = 1'b1;
                end else begin
                    if (Ovr_Clear[i]) m_ovr[i] = 1'b0;
                    if (Ch_Start[i]) begin
                        m_pend[i] = 1'b1;
                        m_hold[i] = int'(Ch_Data[i*WID_DATA +: WID_DATA]);
                        n_accepted++;
                    end
                end
            end
            if (any && !full) begin
                m_q.push_back(g * 256 + m_hold[g]);
                m_pend[g] = 1'b0;
                m_last    = g;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge Clock) begin
        if (model_live) begin : cmp
            logic [NUM_CH-1:0] exp_busy;
            for (int i = 0; i < NUM_CH; i++) exp_busy[i] = m_pend[i];
            check("cmp_valid", 32'(Out_Valid), 32'(m_q.size() != 0));
            check("cmp_busy", 32'(Ch_Busy), 32'(exp_busy));
            if (m_q.size() != 0) begin
                check("cmp_data", 32'(Out_Data), m_q[0] % 256);
                check("cmp_channel", 32'(Out_Channel), m_q[0] / 256);
            end
`ifdef HS_OVERRUN_EN
            for (int i = 0; i < NUM_CH; i++) check("cmp_ovr", 32'(Ovr_Flags[i]), 32'(m_ovr[i]));
`endif
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        Ch_Start  = '0;
        Ovr_Clear = '0;
        step();
        step();
        Reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and single-word latency on channel 2.
        do_reset();
        @(negedge Clock);
        check("rst_valid", 32'(Out_Valid), 0);
        check("rst_busy", 32'(Ch_Busy), 0);
        check("rst_data", 32'(Out_Data), 0);
        check("rst_channel", 32'(Out_Channel), 0);
        Ch_Start  = 4'b0100;
        Ch_Data   = 32'h00A5_0000;
        Out_Ready = 1'b1;
        step();
        Ch_Start = '0;
        @(negedge Clock);
        check("lat_busy_c1", 32'(Ch_Busy[2]), 1);
        check("lat_valid_c1", 32'(Out_Valid), 0);
        step();
        @(negedge Clock);
        check("lat_valid_c2", 32'(Out_Valid), 1);
        check("lat_data_c2", 32'(Out_Data), 32'hA5);
        check("lat_channel_c2", 32'(Out_Channel), 2);
        check("lat_busy_c2", 32'(Ch_Busy[2]), 0);

        // All four channels at once: delivered in channel order 0..3.
        do_reset();
        Out_Ready = 1'b1;
        Ch_Start  = 4'hF;
        Ch_Data   = 32'h1312_1110;
        step();
        Ch_Start = '0;
        step();
        for (int k = 0; k < NUM_CH; k++) begin
            @(negedge Clock);
            check("order_channel", 32'(Out_Channel), k);
            check("order_data", 32'(Out_Data), 32'h10 + k);
            step();
        end
        @(negedge Clock);
        check("order_drained", 32'(Out_Valid), 0);

        // Fill to DEPTH with one extra pending word under back-pressure.
        Out_Ready = 1'b0;
        Ch_Start  = 4'hF;
        Ch_Data   = 32'h2322_2120;
        step();
        Ch_Start = '0;
        step();
        Ch_Start     = 4'b0001;
        Ch_Data[7:0] = 8'h30;
        step();
        Ch_Start = '0;
        repeat (6) step();
        @(negedge Clock);
        check("full_busy", 32'(Ch_Busy), 32'b0001);
        check("full_head_ch", 32'(Out_Channel), 0);
        check("full_head_data", 32'(Out_Data), 32'h20);
        Out_Ready = 1'b1;
        step();
        Out_Ready = 1'b0;
        @(negedge Clock);
        check("full_push_blocked", 32'(Ch_Busy), 32'b0001);
        check("full_new_head", 32'(Out_Channel), 1);
        step();
        @(negedge Clock);
        check("full_push_after", 32'(Ch_Busy), 0);
        Out_Ready = 1'b1;
        repeat (3) step();
        @(negedge Clock);
        check("full_tail_ch", 32'(Out_Channel), 0);
        check("full_tail_data", 32'(Out_Data), 32'h30);
        step();
        @(negedge Clock);
        check("full_empty", 32'(Out_Valid), 0);

        // Overrun: second start one cycle later is dropped.
        Ch_Start = 4'b0010;
        Ch_Data  = 32'h0000_0100;
        step();
        Ch_Data  = 32'h0000_0200;
        step();
        Ch_Start = '0;
        @(negedge Clock);
        check("ovr_data", 32'(Out_Data), 32'h01);
        check("ovr_channel", 32'(Out_Channel), 1);
        step();
        @(negedge Clock);
        check("ovr_only_one", 32'(Out_Valid), 0);
`ifdef HS_OVERRUN_EN
        check("ovr_flag_set", 32'(Ovr_Flags[1]), 1);
        Ovr_Clear = 4'b0010;
        step();
        Ovr_Clear = '0;
        @(negedge Clock);
        check("ovr_flag_clr", 32'(Ovr_Flags[1]), 0);
`endif

        // Reset with 3 queued and 2 pending discards everything.
        do_reset();
        Out_Ready = 1'b0;
        Ch_Start  = 4'hF;
        Ch_Data   = 32'h4342_4140;
        step();
        Ch_Start = '0;
        step();
        Ch_Start     = 4'b0001;
        Ch_Data[7:0] = 8'h50;
        step();
        Ch_Start = '0;
        step();
        @(negedge Clock);
        check("pre_rst_busy", 32'(Ch_Busy), 32'b1001);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        @(negedge Clock);
        check("mid_rst_valid", 32'(Out_Valid), 0);
        check("mid_rst_busy", 32'(Ch_Busy), 0);
        check("mid_rst_data", 32'(Out_Data), 0);
        Out_Ready = 1'b1;
        Ch_Start  = 4'b1000;
        Ch_Data   = 32'h7700_0000;
        step();
        Ch_Start = '0;
        step();
        @(negedge Clock);
        check("post_rst_channel", 32'(Out_Channel), 3);
        check("post_rst_data", 32'(Out_Data), 32'h77);
        step();
        @(negedge Clock);
        check("post_rst_empty", 32'(Out_Valid), 0);

        // Sustained all-pending traffic with Out_Ready toggling.
        do_reset();
        rr_prev = -1;
        rr_en   = 1'b1;
        for (int c = 0; c < 64; c++) begin
            Ch_Start  = 4'hF;
            Ch_Data   = $urandom;
            Out_Ready = c[0];
            step();
        end
        Ch_Start = '0;
        rr_en    = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            Ch_Start  = 4'($urandom);
            Ch_Data   = $urandom;
            Out_Ready = ($urandom_range(0, 3) != 0);
            Ovr_Clear = 4'($urandom);
            step();
        end
        Ch_Start  = '0;
        Ovr_Clear = '0;
        Out_Ready = 1'b1;

        begin : drain
            bit done;
            done = 1'b0;
            for (int c = 0; c < 100 && !done; c++) begin
                step();
                if (!Out_Valid && Ch_Busy == '0) done = 1'b1;
            end
            check("drain_done", 32'(done), 1);
        end
        check("conservation", n_delivered, n_accepted);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
